// File: rtl/axi_resp_pkg.sv
// Shared constants and types for the AXI write-response router.
// Master select codes live in BID[7:4] of the slave-side ID.
package axi_resp_pkg;

   localparam int NUM_SLAVES = 6;

   localparam logic [3:0] MSEL_M1 = 4'b0010;
   localparam logic [3:0] MSEL_M2 = 4'b0100;

   typedef logic [1:0] bresp_t;
   localparam bresp_t OKAY   = 2'b00;
   localparam bresp_t EXOKAY = 2'b01;
   localparam bresp_t SLVERR = 2'b10;
   localparam bresp_t DECERR = 2'b11;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ostate_t;

   // Saturating 8-bit accumulate used by the drop counter.
   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {5'd0, b};
      return (sum > 9'd255) ? 8'hFF : sum[7:0];
   endfunction

endpackage

// File: rtl/resp_rr_arb.sv
// Round-robin arbiter: grants the first request after the last winner,
// wrapping; the pointer only moves when a grant is issued.
module resp_rr_arb
   import axi_resp_pkg::*;
#(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_req,
   input  logic         i_load,
   output logic [N-1:0] o_grant,
   output logic [2:0]   o_rr_ptr
);

   logic [2:0]   r_ptr;
   logic [N-1:0] w_grant;
   logic [2:0]   w_gidx;
   logic         w_found;

   always_comb begin
      w_grant = '0;
      w_gidx  = r_ptr;
      w_found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         int idx;
         idx = (int'(r_ptr) + k) % N;
         if (!w_found && i_load && i_req[idx]) begin
            w_found      = 1'b1;
            w_grant[idx] = 1'b1;
            w_gidx       = 3'(idx);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr <= 3'(N - 1);
      end else if (w_found) begin
         r_ptr <= w_gidx;
      end
   end

   assign o_grant  = w_grant;
   assign o_rr_ptr = r_ptr;

endmodule

// File: rtl/axi_wresp_router.sv
// B-channel router: six slaves to two masters, each master with a one-entry
// registered stage and its own round-robin arbiter; undecodable IDs are dropped.
module axi_wresp_router
   import axi_resp_pkg::*;
#(
   parameter int AXI_ID_BITS  = 4,
   parameter int AXI_IDS_BITS = 8,
   parameter int NUM_SLAVES   = axi_resp_pkg::NUM_SLAVES
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [NUM_SLAVES-1:0][AXI_IDS_BITS-1:0] BID_S,
   input  logic [NUM_SLAVES-1:0][1:0]              BRESP_S,
   input  logic [NUM_SLAVES-1:0]                   BVALID_S,
   output logic [NUM_SLAVES-1:0]                   BREADY_S,
   output logic [AXI_ID_BITS-1:0]                  BID_M1,
   output logic [1:0]                              BRESP_M1,
   output logic                                    BVALID_M1,
   input  logic                                    BREADY_M1,
   output logic [AXI_ID_BITS-1:0]                  BID_M2,
   output logic [1:0]                              BRESP_M2,
   output logic                                    BVALID_M2,
   input  logic                                    BREADY_M2,
   output logic [7:0]                              drop_cnt,
   output ostate_t                                 o_dbg_state_m1,
   output ostate_t                                 o_dbg_state_m2,
   output logic [2:0]                              o_dbg_rr_m1,
   output logic [2:0]                              o_dbg_rr_m2
);

   ostate_t                r_state   [2];
   logic [AXI_ID_BITS-1:0] r_id      [2];
   bresp_t                 r_resp    [2];
   logic [7:0]             r_drop_cnt;

   logic [NUM_SLAVES-1:0]  w_req     [2];
   logic [NUM_SLAVES-1:0]  w_gnt     [2];
   logic [2:0]             w_rr      [2];
   logic [1:0]             w_load;
   logic [1:0]             w_mrdy;
   logic [AXI_ID_BITS-1:0] w_ld_id   [2];
   bresp_t                 w_ld_resp [2];
   logic [NUM_SLAVES-1:0]  w_drop;
   logic [3:0]             w_ndrop;

   assign w_mrdy = {BREADY_M2, BREADY_M1};

   always_comb begin
      w_req[0] = '0;
      w_req[1] = '0;
      w_drop   = '0;
      w_ndrop  = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         if (BVALID_S[s]) begin
            if (BID_S[s][AXI_IDS_BITS-1 -: 4] == MSEL_M1) begin
               w_req[0][s] = 1'b1;
            end else if (BID_S[s][AXI_IDS_BITS-1 -: 4] == MSEL_M2) begin
               w_req[1][s] = 1'b1;
            end else begin
               w_drop[s] = 1'b1;
               w_ndrop   = w_ndrop + 4'd1;
            end
         end
      end
   end

   // A stage may take a new beat when empty or when its current beat leaves this cycle.
   always_comb begin
      for (int m = 0; m < 2; m++) begin
         w_load[m] = !rst && ((r_state[m] == EMPTY) || w_mrdy[m]);
      end
   end

   for (genvar m = 0; m < 2; m++) begin : g_arb
      resp_rr_arb #(.N(NUM_SLAVES)) u_arb (
         .clk      (clk),
         .rst      (rst),
         .i_req    (w_req[m]),
         .i_load   (w_load[m]),
         .o_grant  (w_gnt[m]),
         .o_rr_ptr (w_rr[m])
      );
   end

   always_comb begin
      for (int m = 0; m < 2; m++) begin
         w_ld_id[m]   = '0;
         w_ld_resp[m] = OKAY;
         for (int s = 0; s < NUM_SLAVES; s++) begin
            if (w_gnt[m][s]) begin
               w_ld_id[m]   = BID_S[s][AXI_ID_BITS-1:0];
               w_ld_resp[m] = BRESP_S[s];
            end
         end
      end
   end

   assign BREADY_S = rst ? '0 : (w_gnt[0] | w_gnt[1] | w_drop);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int m = 0; m < 2; m++) begin
            r_state[m] <= EMPTY;
            r_id[m]    <= '0;
            r_resp[m]  <= OKAY;
         end
         r_drop_cnt <= '0;
      end else begin
         for (int m = 0; m < 2; m++) begin
            case (r_state[m])
               EMPTY: begin
                  if (|w_gnt[m]) begin
                     r_state[m] <= FULL;
                     r_id[m]    <= w_ld_id[m];
                     r_resp[m]  <= w_ld_resp[m];
                  end
               end
               FULL: begin
                  if (w_mrdy[m]) begin
                     if (|w_gnt[m]) begin
                        r_id[m]   <= w_ld_id[m];
                        r_resp[m] <= w_ld_resp[m];
                     end else begin
                        r_state[m] <= EMPTY;
                     end
                  end
               end
            endcase
         end
         r_drop_cnt <= sat_add8(r_drop_cnt, w_ndrop);
      end
   end

   assign BVALID_M1      = (r_state[0] == FULL);
   assign BID_M1         = r_id[0];
   assign BRESP_M1       = r_resp[0];
   assign BVALID_M2      = (r_state[1] == FULL);
   assign BID_M2         = r_id[1];
   assign BRESP_M2       = r_resp[1];
   assign drop_cnt       = r_drop_cnt;
   assign o_dbg_state_m1 = r_state[0];
   assign o_dbg_state_m2 = r_state[1];
   assign o_dbg_rr_m1    = w_rr[0];
   assign o_dbg_rr_m2    = w_rr[1];

endmodule
